// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong match sequencer.
package pong_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;

  localparam int DEF_WIN_SCORE    = 7;
  localparam int DEF_SERVE_FRAMES = 60;
  localparam int DEF_POINT_FRAMES = 90;

  // Conditioned single-cycle events; field order matches the sync_edge lane index.
  typedef struct packed {
    logic miss_r;
    logic miss_l;
    logic press;
    logic tick;
  } evt_t;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Raw game inputs and sequencer outputs between the pong datapath and its controller.
interface pong_game_ctrl_if #(
  parameter int SCORE_W = 4
);
  logic               vsync;
  logic               start_n;
  logic               pause;
  logic               miss_left;
  logic               miss_right;
  logic               ball_hold;
  logic               ball_run;
  logic               serve_dir;
  logic [SCORE_W-1:0] score0;
  logic [SCORE_W-1:0] score1;
  logic [1:0]         winner;
  logic [2:0]         state;

  modport master (
    output vsync, start_n, pause, miss_left, miss_right,
    input  ball_hold, ball_run, serve_dir, score0, score1, winner, state
  );

  modport slave (
    input  vsync, start_n, pause, miss_left, miss_right,
    output ball_hold, ball_run, serve_dir, score0, score1, winner, state
  );
endinterface

// File: rtl/sync_edge.sv
// 2-flop synchroniser followed by a registered edge detector; emits a 1-cycle pulse.
module sync_edge #(
  parameter bit RISE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);
  // sh[1:0] synchronise, sh[2] holds the previous synced value
  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh    <= '0;
      pulse <= 1'b0;
    end else begin
      sh    <= {sh[1:0], d};
      pulse <= RISE ? (sh[1] & ~sh[2]) : (~sh[1] & sh[2]);
    end
  end
endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve/rally/point phases, frame timing, scores and winner.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
  parameter int POINT_FRAMES = DEF_POINT_FRAMES,
  parameter int FCNT_W       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  pong_game_ctrl_if.slave bus
);
  localparam int                 NUM_EVT    = 4;
  localparam logic [NUM_EVT-1:0] RISE_MASK  = 4'b1100;
  localparam logic [FCNT_W-1:0]  SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
  localparam logic [FCNT_W-1:0]  POINT_LAST = FCNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);

  logic [NUM_EVT-1:0] raw, pls;
  evt_t               evt;
  logic [1:0]         pause_sh;
  logic               pause_s;

  assign raw = {bus.miss_right, bus.miss_left, bus.start_n, bus.vsync};

  // lanes 0/1 are active-low (falling edge), lanes 2/3 are miss levels (rising edge)
  for (genvar i = 0; i < NUM_EVT; i++) begin : g_se
    sync_edge #(.RISE(RISE_MASK[i])) u_se (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (raw[i]),
      .pulse (pls[i])
    );
  end

  assign evt = evt_t'(pls);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pause_sh <= '0;
    else        pause_sh <= {pause_sh[0], bus.pause};
  end
  assign pause_s = pause_sh[1];

  state_t             st;
  logic [FCNT_W-1:0]  fcnt;
  logic [SCORE_W-1:0] score0, score1;
  logic [1:0]         winner;
  logic               ball_hold, ball_run, serve_dir;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v >= WIN_S) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      fcnt      <= '0;
      score0    <= '0;
      score1    <= '0;
      winner    <= WIN_NONE;
      ball_hold <= 1'b1;
      ball_run  <= 1'b0;
      serve_dir <= 1'b0;
    end else begin
      case (st)
        IDLE, OVER: begin
          if (evt.press) begin
            st        <= SERVE;
            fcnt      <= '0;
            score0    <= '0;
            score1    <= '0;
            winner    <= WIN_NONE;
            serve_dir <= 1'b1;
            ball_hold <= 1'b1;
            ball_run  <= 1'b0;
          end
        end
        SERVE: begin
          if (evt.tick && !pause_s) begin
            if (fcnt == SERVE_LAST) begin
              st        <= PLAY;
              fcnt      <= '0;
              ball_hold <= 1'b0;
              ball_run  <= 1'b1;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end
        PLAY: begin
          ball_run <= !pause_s;
          if (evt.miss_l || evt.miss_r) begin
            st       <= POINT;
            fcnt     <= '0;
            ball_run <= 1'b0;
            if (evt.miss_l && evt.miss_r) begin
              serve_dir <= ~serve_dir;
            end else if (evt.miss_l) begin
              score1    <= sat_inc(score1);
              serve_dir <= 1'b0;
            end else begin
              score0    <= sat_inc(score0);
              serve_dir <= 1'b1;
            end
          end
        end
        POINT: begin
          if (evt.tick && !pause_s) begin
            if (fcnt == POINT_LAST) begin
              fcnt      <= '0;
              ball_hold <= 1'b1;
              if (score0 == WIN_S) begin
                st     <= OVER;
                winner <= WIN_P0;
              end else if (score1 == WIN_S) begin
                st     <= OVER;
                winner <= WIN_P1;
              end else begin
                st <= SERVE;
              end
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end
        default: begin
          st        <= IDLE;
          fcnt      <= '0;
          ball_hold <= 1'b1;
          ball_run  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ball_hold = ball_hold;
  assign bus.ball_run  = ball_run;
  assign bus.serve_dir = serve_dir;
  assign bus.score0    = score0;
  assign bus.score1    = score1;
  assign bus.winner    = winner;
  assign bus.state     = st;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomised match bench for pong_game_ctrl against a phase-level match model.
module tb_pong_game_ctrl;
  localparam int SF  = 60;
  localparam int PF  = 90;
  localparam int WIN = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pong_game_ctrl_if #(.SCORE_W(4)) bus();

  pong_game_ctrl #(
    .WIN_SCORE(WIN), .SCORE_W(4), .SERVE_FRAMES(SF), .POINT_FRAMES(PF), .FCNT_W(8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  // match model: phase, scores, serve direction, winner, pause level
  int e_st, e_s0, e_s1, e_dir, e_win, e_pause;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},  int'(bus.state),     e_st);
    chk({tag, ".hold"},   int'(bus.ball_hold), (e_st == 0 || e_st == 1 || e_st == 4) ? 1 : 0);
    chk({tag, ".run"},    int'(bus.ball_run),  (e_st == 2 && e_pause == 0) ? 1 : 0);
    chk({tag, ".dir"},    int'(bus.serve_dir), e_dir);
    chk({tag, ".score0"}, int'(bus.score0),    e_s0);
    chk({tag, ".score1"}, int'(bus.score1),    e_s1);
    chk({tag, ".winner"}, int'(bus.winner),    e_win);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      bus.vsync = 1'b0; cyc(3);
      bus.vsync = 1'b1; cyc(3);
    end
  endtask

  task automatic set_pause(input int p);
    bus.pause = p[0];
    e_pause = p;
    cyc(4);
  endtask

  task automatic press();
    bus.start_n = 1'b0; cyc(3);
    bus.start_n = 1'b1; cyc(5);
  endtask

  task automatic model_reset();
    e_st = 0; e_s0 = 0; e_s1 = 0; e_dir = 0; e_win = 0; e_pause = 0;
  endtask

  task automatic model_new_match();
    e_st = 1; e_s0 = 0; e_s1 = 0; e_dir = 1; e_win = 0;
  endtask

  // serve needs SF unpaused ticks; paused ticks are added somewhere in between
  task automatic do_serve(input int paused);
    int a;
    a = $urandom_range(0, SF - 1);
    frames(a);
    if (paused > 0) begin
      set_pause(1);
      frames(paused);
      check_all("serve_paused");
      set_pause(0);
    end
    if ($urandom_range(0, 1) == 1) press();
    frames(SF - 1 - a);
    check_all("serve_edge");
    frames(1);
    e_st = 2;
    check_all("play_entry");
  endtask

  task automatic do_point(input int kind, input int h);
    int rest, p;
    frames($urandom_range(0, 2));
    if ($urandom_range(0, 3) == 0) press();
    check_all("rally");
    case (kind)
      0: begin bus.miss_left = 1'b1;  e_s1 = (e_s1 < WIN) ? e_s1 + 1 : e_s1; e_dir = 0; end
      1: begin bus.miss_right = 1'b1; e_s0 = (e_s0 < WIN) ? e_s0 + 1 : e_s0; e_dir = 1; end
      default: begin bus.miss_left = 1'b1; bus.miss_right = 1'b1; e_dir = 1 - e_dir; end
    endcase
    cyc(5);
    e_st = 3;
    check_all("miss");
    frames(h);
    bus.miss_left = 1'b0;
    bus.miss_right = 1'b0;
    cyc(4);
    check_all("miss_held");
    rest = PF - 1 - h;
    p = $urandom_range(0, 1) == 1 ? $urandom_range(1, 8) : 0;
    if (p > 0) begin
      set_pause(1);
      frames(p);
      set_pause(0);
    end
    if ($urandom_range(0, 1) == 1) press();
    bus.miss_right = 1'b1; cyc(5); bus.miss_right = 1'b0; cyc(4);
    frames(rest);
    check_all("point_edge");
    frames(1);
    if (e_s0 == WIN) begin e_st = 4; e_win = 1; end
    else if (e_s1 == WIN) begin e_st = 4; e_win = 2; end
    else e_st = 1;
    check_all("point_exit");
  endtask

  function automatic int rand_kind();
    int r;
    r = $urandom_range(0, 19);
    return (r < 9) ? 0 : (r < 18) ? 1 : 2;
  endfunction

  initial begin
    int n;
    bus.vsync = 1'b1; bus.start_n = 1'b1; bus.pause = 1'b0;
    bus.miss_left = 1'b0; bus.miss_right = 1'b0;
    model_reset();
    cyc(3);
    check_all("reset");
    rst_n = 1'b1;
    cyc(5);
    check_all("idle");

    bus.miss_left = 1'b1; cyc(6); bus.miss_left = 1'b0; cyc(4);
    frames(3);
    check_all("idle_miss");

    press();
    model_new_match();
    check_all("start");

    do_serve(30);
    bus.pause = 1'b1; cyc(3);
    chk("play_pause.run", int'(bus.ball_run), 0);
    bus.pause = 1'b0; cyc(3);
    chk("play_resume.run", int'(bus.ball_run), 1);
    do_point(0, 5);

    n = 0;
    while (e_st != 4 && n < 60) begin
      do_serve($urandom_range(0, 1) == 1 ? $urandom_range(1, 10) : 0);
      do_point(rand_kind(), $urandom_range(1, 5));
      n++;
    end
    chk("match_over", e_st, 4);

    bus.miss_left = 1'b1; cyc(6); bus.miss_left = 1'b0; cyc(2);
    bus.miss_right = 1'b1; cyc(6); bus.miss_right = 1'b0; cyc(4);
    frames(4);
    check_all("over_miss");

    press();
    model_new_match();
    check_all("restart");

    for (int i = 0; i < 3; i++) begin
      do_serve(0);
      do_point(rand_kind(), $urandom_range(1, 5));
    end
    do_serve(0);
    frames(2);
    check_all("pre_reset");

    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    check_all("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
